// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared state encoding and default width for the bit-serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// Module   : full_adder_bit
// Purpose  : Combinational 1-bit full adder built from two half-adder stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_hs0;
  logic w_hc0;
  logic w_hc1;

  assign w_hs0  = i_a ^ i_b;
  assign w_hc0  = i_a & i_b;
  assign o_s    = w_hs0 ^ i_cin;
  assign w_hc1  = w_hs0 & i_cin;
  assign o_cout = w_hc0 | w_hc1;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit unsigned adder, LSB-first, one bit per clock.
//            Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  full_adder_bit u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // r_b_sh doubles as the accumulator: sum bits enter at the MSB as b drains out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {w_s, r_b_sh[WIDTH-1:1]};
          r_carry <= w_c;
          if (w_last) begin
            r_sum  <= {w_s, r_b_sh[WIDTH-1:1]};
            r_cout <= w_c;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last step r_carry is the carry into the MSB and w_c the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8), directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1..W = serial steps, W+1 = done cycle.
  int           m_phase = 0;
  logic [W:0]   m_res   = '0;
  logic         m_ovf_n = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_res   = {1'b0, a} + {1'b0, b};
        m_ovf_n = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
        m_phase = 1;
      end
    end else if (m_phase <= W) begin
      if (m_phase == W) begin
        m_sum  = m_res[W-1:0];
        m_cout = m_res[W];
        m_ovf  = m_ovf_n;
      end
      m_phase = m_phase + 1;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
      chk("model_done", {31'd0, done}, {31'd0, (m_phase == W + 1)});
      chk("model_sum",  {24'd0, sum},  {24'd0, m_sum});
      chk("model_cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef SERIAL_ADDER_OVF_EN
      chk("model_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
`endif
    end
  end

  // Called one time step after a rising edge while idle; returns likewise, idle.
  task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    int nbusy;
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    n     = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!done && n < 20);
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_busy_cycles"}, nbusy, 9);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected x ovf vector");
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    logic [W-1:0] rsum;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum",  {24'd0, sum},  32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    repeat (5) @(posedge clk);
    #1;

    do_op("basic",  8'd23,  8'd19,  8'd42,  1'b0, 1'b0);
    do_op("c255p1", 8'd255, 8'd1,   8'd0,   1'b1, 1'b0);
    do_op("c200",   8'd200, 8'd100, 8'd44,  1'b1, 1'b0);
    do_op("o127p1", 8'd127, 8'd1,   8'd128, 1'b0, 1'b1);
    do_op("o128",   8'd128, 8'd128, 8'd0,   1'b1, 1'b1);

    // Second start arriving in cycle 4 of a running operation must be ignored.
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    rsum  = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        rsum = sum;
      end
    end
    chk("ignored_start_ndone", ndone, 1);
    chk("ignored_start_sum", {24'd0, rsum}, 32'd2);
    @(posedge clk);
    #1;

    // Reset in cycle 5 abandons the operation and clears the held result.
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum",  {24'd0, sum},  32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    @(posedge clk);
    #1;
    do_op("fresh", 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);

    // start held high: second capture in the first IDLE cycle after DONE.
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd6;
    @(posedge clk);
    #1;
    a     = 8'd10;
    b     = 8'd20;
    d1    = -1;
    d2    = -1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = n;
          chk("b2b_first_sum", {24'd0, sum}, 32'd11);
        end else if (d2 < 0) begin
          d2 = n;
          chk("b2b_second_sum", {24'd0, sum}, 32'd30);
        end
      end
      if (n == 12) start = 1'b0;
    end
    chk("b2b_first_done_cycle", d1, 9);
    chk("b2b_second_done_cycle", d2, 19);
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit unsigned adder: the addition-side counterpart to the lab's subtractor cells, reconstructing a minuend from difference + subtrahend. Operands load in parallel on a start request, one full-add step runs per clock LSB-first through a registered carry, and the result returns in parallel with a one-cycle done pulse. It serves as the sequential arithmetic block beside the combinational adder/subtractor cells in the lab design.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result register, held until next completion
- cout  output  1  carry out of bit WIDTH-1, held with sum
- ovf  output  1  signed overflow flag (only with SERIAL_ADDER_OVF_EN)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → capture a, b into shift registers; carry ← 0; bit counter ← 0; go to SHIFT. start=0 → stay.
- SHIFT, each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry; carry ← majority(a_sh[0], b_sh[0], carry).
  - s shifts into the MSB of the internal accumulator; a_sh, b_sh shift right one bit; counter increments.
  - When counter = WIDTH-1, transfer the final accumulator value to sum and the final carry to cout, then go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
- start in SHIFT or DONE is ignored; it is neither queued nor does it disturb the operation.
- a and b are don't-care except on the accepted-start cycle.
- Arithmetic: {cout, sum} = a + b, modulo 2^(WIDTH+1); no truncation other than that.
- sum, cout, and ovf change only on the SHIFT→DONE transition. They hold the previous result throughout a new operation.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, carry 0, counter 0, shift registers 0.
- Start accepted at edge 0: busy=1 from cycle 1; SHIFT occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1; busy=0 from cycle WIDTH+2.
- Latency: start to done is WIDTH+1 cycles. Minimum start-to-start spacing is WIDTH+2 cycles.
- Back-to-back: start held high continuously is accepted again in the first IDLE cycle after DONE.
- rst has priority on any cycle, including mid-SHIFT and DONE. The operation is abandoned, all outputs take their reset values, and no done pulse is issued.
- Counter width is $clog2(WIDTH). The terminal compare is against WIDTH-1, with no wrap beyond it.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the ovf port.
  - On the final SHIFT cycle, ovf ← carry_into_msb ^ carry_out_of_msb (two's-complement overflow).
  - ovf is registered with sum.
- SERIAL_ADDER_OVF_EN undefined:
  - No ovf port and no extra flop.
  - All other behaviour is identical.

## Structure
- Package serial_adder_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Default WIDTH constant.
- Sub-module full_adder_bit: combinational 1-bit cell (a, b, cin → s, cout), built as two half-adder stages with OR of carries. It is instantiated once inside the serial datapath.
- The top contains the FSM, shift registers, counter, carry flop, and result registers.

## Test plan
- Reset then idle: rst high 2 cycles → busy=0, done=0, sum=0, cout=0; start=0 for 5 cycles → no change.
- Basic add, WIDTH=8: a=23, b=19, start 1 cycle → done pulses exactly 9 cycles after the start edge; sum=42, cout=0; busy high for 9 cycles.
- Carry out: a=255, b=1 → sum=0, cout=1. Then a=200, b=100 → sum=44, cout=1.
- Ignored start: start a=1, b=1; pulse start again with a=9, b=9 at cycle 4 → single done; sum=2; no second done.
- Reset mid-operation: start a=100, b=50, assert rst at cycle 5 → no done; all outputs 0. Then a fresh start a=3, b=4 → sum=7.
- With SERIAL_ADDER_OVF_EN:
  - a=127, b=1 → sum=128, ovf=1, cout=0.
  - a=255, b=1 → ovf=0, cout=1.
  - a=128, b=128 → sum=0, ovf=1, cout=1.
